// File: rtl/in_port_conditioner_if.sv
// ---------------------------------------------------------------------------
// in_port_conditioner_if
//   Bundles the raw button/switch nibbles going into the conditioner and the
//   debounced nibbles plus change pulses coming out of it.
//
//   raw_in_0..2   : raw, asynchronous 4-bit nibbles (one per CPU input port)
//   IN_0..2       : debounced, registered nibbles feeding the core
//   port_changed  : bit p pulses for one cycle when IN_p changes
//
//   master : the side that drives raw levels and watches the conditioned ports
//   slave  : the conditioner itself
// ---------------------------------------------------------------------------
interface in_port_conditioner_if;
    logic [3:0] raw_in_0;
    logic [3:0] raw_in_1;
    logic [3:0] raw_in_2;
    logic [3:0] IN_0;
    logic [3:0] IN_1;
    logic [3:0] IN_2;
    logic [2:0] port_changed;

    modport master (
        output raw_in_0, raw_in_1, raw_in_2,
        input  IN_0, IN_1, IN_2, port_changed
    );

    modport slave (
        input  raw_in_0, raw_in_1, raw_in_2,
        output IN_0, IN_1, IN_2, port_changed
    );
endinterface

// File: rtl/in_port_conditioner.sv
// ---------------------------------------------------------------------------
// in_port_conditioner
//   Synchronizes and debounces the three raw 4-bit input nibbles that feed
//   IN_0..IN_2 of the CPU core. Each of the 12 bits has its own synchronizer
//   chain and stability counter; a bit's stable value only moves after the
//   synchronized bit has disagreed with it for DEBOUNCE_CYCLES consecutive
//   clocks. A one-cycle pulse on port_changed[p] accompanies every update of
//   IN_p.
//
//   clk    : system clock, all state on the rising edge
//   reset  : synchronous, active-low; clears synchronizers, counters, outputs
//   bus    : slave side of in_port_conditioner_if (raw in, debounced out)
// ---------------------------------------------------------------------------
module in_port_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    in_port_conditioner_if.slave  bus
);

    localparam int NBITS = 12;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value reached on the last disagreeing cycle before the update.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NBITS-1:0] raw_s;
    logic [NBITS-1:0] sync_q [SYNC_STAGES];
    logic [NBITS-1:0] sync_s;
    logic [CNT_W-1:0] cnt_q  [NBITS];
    logic [CNT_W-1:0] cnt_d  [NBITS];
    logic [NBITS-1:0] stable_q;
    logic [NBITS-1:0] stable_d;
    logic [NBITS-1:0] upd_s;
    logic [2:0]       changed_q;
    logic [2:0]       changed_d;

    // Port p occupies bits [4p+3:4p] of the flattened vectors.
    assign raw_s  = {bus.raw_in_2, bus.raw_in_1, bus.raw_in_0};
    assign sync_s = sync_q[SYNC_STAGES-1];

    // Synchronizer chains: stage 0 captures the raw level, last stage feeds the filter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= raw_s;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Per-bit stability filter and per-port change detection.
    always_comb begin
        stable_d = stable_q;
        upd_s    = '0;
        for (int b = 0; b < NBITS; b++) begin
            cnt_d[b] = '0;
            if (sync_s[b] != stable_q[b]) begin
                if (cnt_q[b] == CNT_LAST) begin
                    // Deviation has lasted long enough: accept it and restart.
                    stable_d[b] = sync_s[b];
                    upd_s[b]    = 1'b1;
                    cnt_d[b]    = '0;
                end else begin
                    cnt_d[b] = cnt_q[b] + CNT_W'(1);
                end
            end else begin
                // Any agreement discards a partial count, so glitches never accumulate.
                cnt_d[b] = '0;
            end
        end
        changed_d[0] = |upd_s[3:0];
        changed_d[1] = |upd_s[7:4];
        changed_d[2] = |upd_s[11:8];
    end

    // Filter state, stable values and change pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stable_q  <= '0;
            changed_q <= 3'b000;
            for (int b = 0; b < NBITS; b++) begin
                cnt_q[b] <= '0;
            end
        end else begin
            stable_q  <= stable_d;
            changed_q <= changed_d;
            for (int b = 0; b < NBITS; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
        end
    end

    assign bus.IN_0         = stable_q[3:0];
    assign bus.IN_1         = stable_q[7:4];
    assign bus.IN_2         = stable_q[11:8];
    assign bus.port_changed = changed_q;

endmodule

// File: tb/tb_in_port_conditioner.sv
// ---------------------------------------------------------------------------
// tb_in_port_conditioner
//   Self-checking bench for in_port_conditioner: a table of reset/step
//   vectors, hand-written multi-cycle corner sequences, and a randomized run
//   compared every cycle against a window-based reference model.
// ---------------------------------------------------------------------------
module tb_in_port_conditioner;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    in_port_conditioner_if bus ();

    in_port_conditioner #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: history of captured raw words and of the
    // synchronized words the filter has seen since the last reset.
    logic [11:0] cap_q [$];
    logic [11:0] fin_q [$];
    logic [11:0] m_stable = 12'h000;
    logic [2:0]  m_chg    = 3'b000;

    typedef struct packed {
        logic       rst;
        logic [3:0] r0;
        logic [3:0] r1;
        logic [3:0] r2;
        logic [3:0] e0;
        logic [3:0] e1;
        logic [3:0] e2;
        logic [2:0] ec;
    } vec_t;

    vec_t vecs [$];

    // A bit flips once the synchronized value has differed from it on each of
    // the last DEBOUNCE_CYCLES edges since reset; synchronized value at an
    // edge is the raw word captured SYNC_STAGES edges earlier.
    task automatic model_edge(input logic rst_v, input logic [11:0] raw);
        logic [11:0] s;
        logic [11:0] flip;
        logic        all_diff;
        if (!rst_v) begin
            cap_q.delete();
            fin_q.delete();
            for (int i = 0; i < SYNC_STAGES; i++) cap_q.push_back(12'h000);
            m_stable = 12'h000;
            m_chg    = 3'b000;
        end else begin
            s = cap_q[cap_q.size() - SYNC_STAGES];
            cap_q.push_back(raw);
            if (cap_q.size() > 8) void'(cap_q.pop_front());
            fin_q.push_back(s);
            if (fin_q.size() > DEBOUNCE_CYCLES) void'(fin_q.pop_front());
            flip = 12'h000;
            for (int b = 0; b < 12; b++) begin
                all_diff = (fin_q.size() == DEBOUNCE_CYCLES);
                foreach (fin_q[i]) begin
                    if (fin_q[i][b] == m_stable[b]) all_diff = 1'b0;
                end
                flip[b] = all_diff;
            end
            m_stable = m_stable ^ flip;
            m_chg    = {|flip[11:8], |flip[7:4], |flip[3:0]};
        end
    endtask

    task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got IN2/IN1/IN0/chg=%h/%h/%h/%b expected %h/%h/%h/%b",
                     name, $time, got[14:11], got[10:7], got[6:3], got[2:0],
                     exp[14:11], exp[10:7], exp[6:3], exp[2:0]);
        end
    endtask

    function automatic logic [14:0] dut_out();
        return {bus.IN_2, bus.IN_1, bus.IN_0, bus.port_changed};
    endfunction

    // One clock: drive inputs well after the previous edge, advance model at
    // the edge, compare outputs 1 time unit later.
    task automatic tick(input logic rst_v, input logic [3:0] r0, input logic [3:0] r1,
                        input logic [3:0] r2);
        reset        = rst_v;
        bus.raw_in_0 = r0;
        bus.raw_in_1 = r1;
        bus.raw_in_2 = r2;
        @(posedge clk);
        model_edge(rst_v, {r2, r1, r0});
        #1;
        check("model", dut_out(), {m_stable, m_chg});
    endtask

    task automatic expect_out(input string name, input logic [3:0] e0, input logic [3:0] e1,
                              input logic [3:0] e2, input logic [2:0] ec);
        check(name, dut_out(), {e2, e1, e0, ec});
    endtask

    task automatic do_reset();
        tick(1'b0, 4'h0, 4'h0, 4'h0);
        expect_out("reset_clear", 4'h0, 4'h0, 4'h0, 3'b000);
        tick(1'b1, 4'h0, 4'h0, 4'h0);
        tick(1'b1, 4'h0, 4'h0, 4'h0);
    endtask

    logic [3:0] rr0, rr1, rr2;
    logic       rrst;
    logic [3:0] e_in;
    logic [2:0] e_ch;

    initial begin
        bus.raw_in_0 = 4'h0;
        bus.raw_in_1 = 4'h0;
        bus.raw_in_2 = 4'h0;

        // Reset with raw high, release, then a clean step on port 1.
        for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 3'b000});
        for (int i = 0; i < 5; i++) vecs.push_back('{1'b1, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 3'b000});
        vecs.push_back('{1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 3'b111});
        vecs.push_back('{1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 3'b000});
        for (int i = 0; i < 5; i++) vecs.push_back('{1'b1, 4'hF, 4'hA, 4'hF, 4'hF, 4'hF, 4'hF, 3'b000});
        vecs.push_back('{1'b1, 4'hF, 4'hA, 4'hF, 4'hF, 4'hA, 4'hF, 3'b010});
        vecs.push_back('{1'b1, 4'hF, 4'hA, 4'hF, 4'hF, 4'hA, 4'hF, 3'b000});

        foreach (vecs[i]) begin
            tick(vecs[i].rst, vecs[i].r0, vecs[i].r1, vecs[i].r2);
            check("table", dut_out(), {vecs[i].e2, vecs[i].e1, vecs[i].e0, vecs[i].ec});
        end

        // Glitch: 3-cycle pulse on port 0 bit 0 must be rejected.
        do_reset();
        for (int k = 1; k <= 11; k++) begin
            tick(1'b1, (k <= 3) ? 4'h1 : 4'h0, 4'h0, 4'h0);
            expect_out("glitch3", 4'h0, 4'h0, 4'h0, 3'b000);
        end
        // Non-consecutive deviations (3 high, 1 low, 3 high) do not add up.
        for (int k = 1; k <= 15; k++) begin
            tick(1'b1, ((k <= 3) || (k >= 5 && k <= 7)) ? 4'h1 : 4'h0, 4'h0, 4'h0);
            expect_out("glitch313", 4'h0, 4'h0, 4'h0, 3'b000);
        end

        // Threshold: exactly 4 cycles high on port 2 bit 3 is accepted, then released.
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            tick(1'b1, 4'h0, 4'h0, (k <= 4) ? 4'h8 : 4'h0);
            e_in = (k >= 6 && k <= 9) ? 4'h8 : 4'h0;
            e_ch = (k == 6 || k == 10) ? 3'b100 : 3'b000;
            expect_out("threshold", 4'h0, 4'h0, e_in, e_ch);
        end

        // Reset in the middle of a count discards the partial count.
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            tick(1'b1, 4'h5, 4'h0, 4'h0);
            expect_out("midcnt_pre", 4'h0, 4'h0, 4'h0, 3'b000);
        end
        tick(1'b0, 4'h5, 4'h0, 4'h0);
        expect_out("midcnt_rst", 4'h0, 4'h0, 4'h0, 3'b000);
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 4'h5, 4'h0, 4'h0);
            e_in = (k >= 6) ? 4'h5 : 4'h0;
            e_ch = (k == 6) ? 3'b001 : 3'b000;
            expect_out("midcnt_post", e_in, 4'h0, 4'h0, e_ch);
        end

        // Simultaneous change on ports 0 and 2.
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 4'h3, 4'h0, 4'hC);
            e_ch = (k == 6) ? 3'b101 : 3'b000;
            if (k >= 6) expect_out("simul", 4'h3, 4'h0, 4'hC, e_ch);
            else        expect_out("simul", 4'h0, 4'h0, 4'h0, e_ch);
        end

        // Skewed bits on port 1: two separate pulses, 0 -> 1 -> 3.
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            tick(1'b1, 4'h0, (k <= 2) ? 4'h1 : 4'h3, 4'h0);
            e_in = (k >= 8) ? 4'h3 : ((k >= 6) ? 4'h1 : 4'h0);
            e_ch = (k == 6 || k == 8) ? 3'b010 : 3'b000;
            expect_out("skew", 4'h0, e_in, 4'h0, e_ch);
        end

        // Randomized run: levels held for random spans, occasional glitches and resets.
        do_reset();
        rr0 = 4'h0;
        rr1 = 4'h0;
        rr2 = 4'h0;
        for (int n = 0; n < 800; n++) begin
            rrst = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 5) == 0) rr0 = 4'($urandom);
            if ($urandom_range(0, 5) == 0) rr1 = 4'($urandom);
            if ($urandom_range(0, 5) == 0) rr2 = 4'($urandom);
            if ($urandom_range(0, 3) == 0) rr0 = rr0 ^ (4'h1 << $urandom_range(0, 3));
            tick(rrst, rr0, rr1, rr2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
